// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bundles the producer-side push/status signals and the
// uart_tx issue handshake of uart_tx_fifo.
//   slave  : the FIFO itself
//   master : the surrounding logic (producer, ovf_clr source, uart_tx busy)
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 5
);
  logic                    wr_en;
  logic [PAYLOAD_BITS-1:0] wr_data;
  logic                    wr_break;
  logic                    full;
  logic                    empty;
  logic [DEPTH_LOG2:0]     level;
  logic                    overflow;
  logic                    ovf_clr;
  logic                    uart_tx_busy;
  logic                    uart_tx_en;
  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_break;

  modport slave (
    input  wr_en, wr_data, wr_break, ovf_clr, uart_tx_busy,
    output full, empty, level, overflow, uart_tx_en, uart_tx_data, uart_tx_break
  );

  modport master (
    output wr_en, wr_data, wr_break, ovf_clr, uart_tx_busy,
    input  full, empty, level, overflow, uart_tx_en, uart_tx_data, uart_tx_break
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that drains into uart_tx one byte at a time using
// uart_tx's en/busy handshake. Reports level, empty/full and sticky overflow.
// Optional build macro UART_TX_FIFO_BREAK_EN stores a break bit with each byte
// and presents it on uart_tx_break alongside the issue pulse; without it the
// break input is ignored and uart_tx_break is held at 0.
//
// Drain FSM:
//   state   | meaning
//   S_IDLE  | waiting for data and uart_tx idle; pops head and issues en
//   S_ISSUE | en pulse is on the wire this cycle
//   S_GAP   | uart_tx has not raised busy yet; busy is not trusted here
//   S_WAIT  | waiting for uart_tx to drop busy
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 5
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef UART_TX_FIFO_BREAK_EN
  localparam int ENTRY_W = PAYLOAD_BITS + 1;
`else
  localparam int ENTRY_W = PAYLOAD_BITS;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic [DEPTH_LOG2:0]     level_d;
  logic                    full_q;
  logic                    empty_q;
  logic                    overflow_q;
  logic                    push;
  logic                    pop;
  logic                    ovf_evt;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [ENTRY_W-1:0]      head;
  logic                    head_break;
  logic                    tx_en_q;
  logic [PAYLOAD_BITS-1:0] tx_data_q;
  logic                    tx_break_q;

  // Full is judged on the registered (pre-edge) state, so a pop in the same
  // cycle never makes room for a push.
  assign push    = bus.wr_en & ~full_q;
  assign ovf_evt = bus.wr_en & full_q;
  assign head    = mem[rd_ptr_q];

`ifdef UART_TX_FIFO_BREAK_EN
  assign wr_entry   = {bus.wr_break, bus.wr_data};
  assign head_break = head[PAYLOAD_BITS];
`else
  logic unused_wr_break;
  assign unused_wr_break = bus.wr_break;
  assign wr_entry        = bus.wr_data;
  assign head_break      = 1'b0;
`endif

  // Next fill level: push and pop together leave it unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointers, level and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      // level never exceeds DEPTH, so its MSB alone means "full".
      full_q  <= level_d[DEPTH_LOG2];
      empty_q <= (level_d == '0);
      if (ovf_evt) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drain FSM next-state and pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !bus.uart_tx_busy) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.uart_tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered issue outputs: en and break only for the pop cycle, data held.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_break_q <= 1'b0;
    end else begin
      tx_en_q    <= pop;
      tx_break_q <= pop & head_break;
      if (pop) begin
        tx_data_q <= head[PAYLOAD_BITS-1:0];
      end
    end
  end

  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.level         = level_q;
  assign bus.overflow      = overflow_q;
  assign bus.uart_tx_en    = tx_en_q;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.uart_tx_break = tx_break_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a simple uart_tx
// busy model (busy high for 10 cycles starting one cycle after each en).
module tb_uart_tx_fifo;

  localparam int PB    = 8;
  localparam int DL    = 5;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_FIFO_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [PB-1:0] data;
    logic          brk;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.PAYLOAD_BITS(PB), .DEPTH_LOG2(DL)) bus ();

  uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks      = 0;
  int   failures    = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic hold_busy   = 1'b0;
  int   busy_cnt    = 0;
  int   cyc         = 0;
  int   en_count    = 0;
  int   last_en_cyc = -100;
  bit   mon_on      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  assign bus.uart_tx_busy = hold_busy | (busy_cnt != 0);

  // uart_tx stand-in: busy rises the cycle after en and lasts 10 cycles.
  always @(posedge clk) begin
    if (bus.uart_tx_en === 1'b1) busy_cnt <= 10;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end

  // Output monitor, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (mon_on) begin
      if (bus.uart_tx_en === 1'b1) begin
        en_count++;
        chk("en_spacing", 32'((cyc - last_en_cyc) >= 4), 32'd1);
        last_en_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("en_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("tx_data", 32'(bus.uart_tx_data), 32'(mon_e.data));
          chk("tx_break", 32'(bus.uart_tx_break), 32'(mon_e.brk));
        end
      end else begin
        chk("break_idle", 32'(bus.uart_tx_break), 32'd0);
      end
      chk("level", 32'(bus.level), 32'(sb_q.size()));
      chk("empty", 32'(bus.empty), 32'(sb_q.size() == 0));
      chk("full", 32'(bus.full), 32'(sb_q.size() == DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [PB-1:0] d, input logic b);
    exp_t e;
    bus.wr_en    = 1'b1;
    bus.wr_data  = d;
    bus.wr_break = b;
    if (sb_q.size() < DEPTH) begin
      e.data = d;
      e.brk  = b & BRK_EN;
      sb_q.push_back(e);
    end
    tick();
    bus.wr_en    = 1'b0;
    bus.wr_break = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(sb_q.size() == 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    int ec0;
    int ec1;
    int n;

    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.wr_break = 1'b0;
    bus.ovf_clr  = 1'b0;
    tick();
    tick();
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_en", 32'(bus.uart_tx_en), 32'd0);
    chk("rst_data", 32'(bus.uart_tx_data), 32'd0);
    chk("rst_break", 32'(bus.uart_tx_break), 32'd0);
    reset  = 1'b0;
    mon_on = 1'b1;
    tick();

    // Single byte latency and level trajectory.
    ec0 = en_count;
    pc  = cyc;
    push(8'h41, 1'b0);
    chk("t1_level1", 32'(bus.level), 32'd1);
    chk("t1_no_en_yet", 32'(bus.uart_tx_en), 32'd0);
    tick();
    chk("t1_en", 32'(bus.uart_tx_en), 32'd1);
    chk("t1_latency", 32'(last_en_cyc), 32'(pc + 2));
    chk("t1_level0", 32'(bus.level), 32'd0);
    idle(20);
    chk("t1_en_count", 32'(en_count - ec0), 32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd1);

    // Fill to full with busy stuck high (write pointer wraps past 31).
    hold_busy = 1'b1;
    ec0 = en_count;
    for (int i = 0; i < DEPTH; i++) push(PB'(i), 1'b0);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_level32", 32'(bus.level), 32'(DEPTH));

    // Overflow: dropped byte, clear, and set-beats-clear.
    push(8'hEE, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    bus.ovf_clr = 1'b1;
    push(8'hEF, 1'b0);
    bus.ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(bus.overflow), 32'd0);
    chk("ovf_level", 32'(bus.level), 32'(DEPTH));

    hold_busy = 1'b0;
    wait_drain(DEPTH * 20);
    idle(20);
    chk("t2_en_count", 32'(en_count - ec0), 32'(DEPTH));

    // Push and pop on the same edge at level 5.
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(PB'(8'h80 + i), 1'b0);
    tick();
    chk("t3_level5", 32'(bus.level), 32'd5);
    hold_busy = 1'b0;
    ec0 = en_count;
    push(8'h85, 1'b0);
    chk("t3_level_pushpop", 32'(bus.level), 32'd5);
    chk("t3_popped", 32'(en_count - ec0), 32'd1);
    wait_drain(200);
    idle(20);

    // Reset mid-frame discards the queue.
    ec0 = en_count;
    push(8'h90, 1'b0);
    push(8'h91, 1'b0);
    push(8'h92, 1'b0);
    n = 0;
    while (en_count == ec0 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_first_en", 32'(en_count - ec0), 32'd1);
    idle(3);
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    chk("t4_level", 32'(bus.level), 32'd0);
    chk("t4_empty", 32'(bus.empty), 32'd1);
    chk("t4_en", 32'(bus.uart_tx_en), 32'd0);
    ec1 = en_count;
    idle(60);
    chk("t4_no_more_en", 32'(en_count), 32'(ec1));

    // Break bit travels with its byte (only when the feature is built in).
    ec0 = en_count;
    push(8'h55, 1'b1);
    push(8'h66, 1'b0);
    wait_drain(100);
    idle(20);
    chk("t5_en_count", 32'(en_count - ec0), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
